circuit3_vector_driver: RTL and testbench
=========================================

// Module: circuit3_vector_driver
// PURPOSE
// - Upstream stimulus and downstream checker stage for the gate-level circuit_3 under test.
// - Drives a/b/c with all 8 input vectors and waits for gate delays to settle.
// - Samples o and compares it with the golden function.
// - Reports the mismatch count, a per-vector fail bitmap and pass/done.
// - Golden function: o = ~((~a | (~(a&b) ^ c)) | c), which is 1 only for {a,b,c}=3'b110 (vector 6).
// PARAMETERS
// - SETTLE_CYCLES  default 20  cycles waited after each drive before sampling.
//   Must be >= ceil(19 / Tclk); 19 is circuit_3's longest path: nand 5 + xor 3 + or 7 + nor 4.
// - CNT_W  default 5  width of the settle counter. Must hold SETTLE_CYCLES.
// PORTS
// - clk        in   1  rising-edge clock
// - rst        in   1  asynchronous, active-high reset
// - start      in   1  one-cycle pulse that starts a run; honoured only in IDLE or DONE
// - o_dut      in   1  circuit_3 output o
// - a, b, c    out  1  circuit_3 inputs, registered
// - busy       out  1  high from the cycle after start until DONE is entered
// - done       out  1  high in DONE; held until the next accepted start or rst
// - pass       out  1  done && (err_count == 0)
// - err_count  out  4  number of mismatching vectors, 0..8
// - fail_vec   out  8  bit i set if vector i mismatched; i = {a,b,c} as applied
// BEHAVIOUR
// - Reset (async, any state): a=b=c=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
//   Also resets idx=0, settle counter=0, state=IDLE.
// - FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
// - IDLE --start--> DRIVE. Clears err_count, fail_vec and idx; busy rises on the next cycle.
// - DRIVE (1 cycle): {a,b,c} <= vec(idx); counter <= 0; goes to SETTLE.
// - SETTLE: counter increments each cycle; after SETTLE_CYCLES cycles in SETTLE, goes to SAMPLE.
// - SAMPLE (1 cycle): registers o_dut and compares it with the golden value for vec(idx).
//   On mismatch: err_count += 1 and fail_vec[vec(idx)] <= 1.
//   If idx == 7, goes to DONE; otherwise idx += 1 and goes to DRIVE.
// - Per-vector cost is SETTLE_CYCLES + 2 cycles.
//   done rises 8*(SETTLE_CYCLES+2) cycles after the start-accept edge.
// - DONE: a/b/c hold the last vector, busy=0, done=1, pass is valid.
//   start --> DRIVE, with the same clears as from IDLE and done dropping.
// - start in DRIVE/SETTLE/SAMPLE is ignored: no restart and no counter disturbance.
// - idx is 3 bits. The run ends at idx==7; idx never wraps inside a run.
// - err_count cannot exceed 8, so no saturation logic is needed.
// - rst mid-run aborts immediately to the reset values; the run is not resumed.
// - o_dut is sampled only in SAMPLE. Glitches during SETTLE are ignored.
// - Golden check uses a constant table GOLD = 8'b0100_0000, indexed by {a,b,c}.
// CONFIGURATION
// - Macro CIRCUIT3_DRV_GRAY_EN.
// - Defined: vec(idx) = idx ^ (idx >> 1), the Gray order 000,001,011,010,110,111,101,100.
//   Exactly one input toggles per step, which exercises single-input hazards.
// - Undefined: vec(idx) = idx, the binary order 000..111.
// - fail_vec is always indexed by the applied vector value, not by idx, in both builds.
// TESTING
// - Ideal DUT model, SETTLE_CYCLES=20, start pulse -> done after 176 cycles, pass=1, err_count=0, fail_vec=8'h00.
// - o_dut tied 0 -> done, pass=0, err_count=1, fail_vec=8'h40.
// - o_dut tied 1 -> done, pass=0, err_count=7, fail_vec=8'hBF.
// - rst asserted while idx=3 is in SETTLE -> next sample shows a=b=c=0, busy=0, done=0, err_count=0, state IDLE.
// - start re-pulsed during SETTLE -> ignored; run completes at the original 176-cycle point.
//   A start pulse in DONE starts a fresh run with cleared counters.
// - CIRCUIT3_DRV_GRAY_EN defined -> {a,b,c} sequence 0,1,3,2,6,7,5,4.
//   With o_dut tied 0: err_count=1, fail_vec=8'h40.

Source files
------------

// File: rtl/circuit3_vector_driver.sv
// Stimulus/checker for circuit_3: applies all eight {a,b,c} vectors, samples o after settling,
// and accumulates mismatches. Define CIRCUIT3_DRV_GRAY_EN to apply vectors in Gray order.
module circuit3_vector_driver #(
  parameter int unsigned SETTLE_CYCLES = 20,
  parameter int unsigned CNT_W         = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       o_dut,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vec
);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;

  // Golden o indexed by {a,b,c}: only vector 6 yields 1.
  localparam logic [7:0]       GOLD     = 8'b0100_0000;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       abc_q, abc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       err_q, err_d;
  logic [7:0]       fail_q, fail_d;

  function automatic logic [2:0] vec(input logic [2:0] i);
`ifdef CIRCUIT3_DRV_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      abc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      abc_q   <= abc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    abc_d   = abc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = '0;
          err_d   = '0;
          fail_d  = '0;
        end
      end
      DRIVE: begin
        abc_d   = vec(idx_q);
        cnt_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        // abc_q still holds vec(idx_q), so it doubles as the GOLD/fail_vec index.
        if (o_dut != GOLD[abc_q]) begin
          err_d         = err_q + 4'd1;
          fail_d[abc_q] = 1'b1;
        end
        if (idx_q == 3'd7) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign {a, b, c}  = abc_q;
  assign busy       = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == SAMPLE);
  assign done       = (state_q == DONE);
  assign pass       = done && (err_q == 4'd0);
  assign err_count  = err_q;
  assign fail_vec   = fail_q;

endmodule

// File: tb/tb_circuit3_vector_driver.sv
// Scoreboard bench for circuit3_vector_driver: an ideal or stuck-at circuit_3 model feeds o_dut,
// and expected vector order and final results are queued at each start.
module tb_circuit3_vector_driver;

  localparam int unsigned S   = 20;
  localparam int          PER = S + 2;

  logic       clk = 1'b0;
  logic       rst, start, o_dut;
  logic       a, b, c, busy, done, pass;
  logic [3:0] err_count;
  logic [7:0] fail_vec;

  int n_vec = 0;
  int n_err = 0;
  int cur   = 0;
  int mode  = 0;   // 0 ideal circuit_3, 1 o tied 0, 2 o tied 1

  typedef struct {
    logic [3:0] err;
    logic [7:0] fail;
  } res_t;

  logic [2:0] vec_q[$];
  res_t       res_q[$];

  always #5 clk = ~clk;

  circuit3_vector_driver #(.SETTLE_CYCLES(S), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .o_dut    (o_dut),
    .a        (a),
    .b        (b),
    .c        (c),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .fail_vec (fail_vec)
  );

  function automatic logic gold(input logic [2:0] v);
    logic x, y, z;
    {x, y, z} = v;
    return ~((~x | (~(x & y) ^ z)) | z);
  endfunction

  function automatic logic [2:0] tb_vec(input int k);
    logic [2:0] i;
    i = 3'(k);
`ifdef CIRCUIT3_DRV_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  always_comb begin
    o_dut = 1'b0;
    if (mode == 0) o_dut = gold({a, b, c});
    else if (mode == 2) o_dut = 1'b1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic adv(input int tgt);
    while (cur < tgt) begin
      @(negedge clk);
      cur++;
    end
  endtask

  // Called on a negedge; returns on the negedge after the start-accept edge (cur = 0).
  task automatic launch(input int m);
    res_t r;
    logic o;
    mode   = m;
    r.err  = '0;
    r.fail = '0;
    for (int k = 0; k < 8; k++) begin
      vec_q.push_back(tb_vec(k));
      o = (m == 0) ? gold(3'(k)) : (m == 2);
      if (o != gold(3'(k))) begin
        r.err       = r.err + 4'd1;
        r.fail[k]   = 1'b1;
      end
    end
    res_q.push_back(r);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cur   = 0;
  endtask

  task automatic run(input int m, input bit poke);
    res_t       r;
    logic [2:0] v;
    launch(m);
    check("busy_after_start", busy, 1'b1);
    check("done_after_start", done, 1'b0);
    check("err_cleared", err_count, 4'd0);
    check("fail_cleared", fail_vec, 8'h00);
    for (int k = 0; k < 8; k++) begin
      adv(2 + k * PER);
      v = vec_q.pop_front();
      check($sformatf("abc_vec%0d", k), {a, b, c}, v);
      check($sformatf("busy_vec%0d", k), busy, 1'b1);
      if (poke && k == 1) begin
        start = 1'b1;   // lands on a SETTLE edge; must be ignored
        adv(cur + 1);
        start = 1'b0;
      end
    end
    adv(8 * PER - 1);
    check("done_early", done, 1'b0);
    adv(8 * PER);
    r = res_q.pop_front();
    check("done_rise", done, 1'b1);
    check("busy_in_done", busy, 1'b0);
    check("err_count", err_count, r.err);
    check("fail_vec", fail_vec, r.fail);
    check("pass", pass, (r.err == 4'd0));
    adv(8 * PER + 3);
    check("done_held", done, 1'b1);
    check("abc_hold_last", {a, b, c}, tb_vec(7));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    repeat (2) @(negedge clk);
    check("rst_abc", {a, b, c}, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_err", err_count, 4'd0);
    check("rst_fail", fail_vec, 8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_start", busy, 1'b0);

    run(0, 1'b0);   // ideal circuit, from IDLE
    run(1, 1'b1);   // o tied 0, restarted from DONE, stray start in SETTLE
    run(2, 1'b0);   // o tied 1

    // Abort during SETTLE of vector 3 with errors already counted.
    launch(2);
    adv(3 * PER + 5);
    check("pre_abort_err", err_count, 4'd3);
    check("pre_abort_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort_abc", {a, b, c}, 3'b000);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_err", err_count, 4'd0);
    check("abort_fail", fail_vec, 8'h00);
    vec_q.delete();
    res_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_resume", busy, 1'b0);

    run(0, 1'b0);   // IDLE after abort accepts a fresh run

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
